// File: rtl/neuron_pkg.sv
// neuron_pkg: shared constants and helpers for the neuron datapath.
//   N_DEF / ACC_W_DEF / FRAC_DEF : default data width, accumulator width, scale shift
//   SAT_MAX_DEF / SAT_MIN_DEF    : saturation bounds for the default data width
//   sat_shift()                  : arithmetic right shift followed by signed saturation
package neuron_pkg;

  localparam int N_DEF     = 8;
  localparam int ACC_W_DEF = 20;
  localparam int FRAC_DEF  = 4;

  localparam logic signed [N_DEF-1:0] SAT_MAX_DEF = 8'sh7F;
  localparam logic signed [N_DEF-1:0] SAT_MIN_DEF = 8'sh80;

  // Shift acc right by frac (sign preserving) and clamp to the signed n-bit range.
  // The argument is a sign-extended 64-bit copy of the accumulator so the same
  // helper serves any accumulator width up to 64 bits.
  function automatic logic signed [31:0] sat_shift(input logic signed [63:0] acc,
                                                   input int unsigned        frac,
                                                   input int unsigned        n);
    logic signed [63:0] shifted;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    shifted = acc >>> frac;
    hi      = (64'sd1 <<< (n - 32'd1)) - 64'sd1;
    lo      = -(64'sd1 <<< (n - 32'd1));
    if (shifted > hi) begin
      res = hi;
    end else if (shifted < lo) begin
      res = lo;
    end else begin
      res = shifted;
    end
    return res[31:0];
  endfunction

endpackage

// File: rtl/neuron_result_fifo.sv
// neuron_result_fifo: small synchronous result FIFO with valid/ready drain.
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write strobe and value
//   ready           : downstream accept; a pop happens when valid & ready
//   valid, data     : head valid and head value (0 when empty)
//   count, full     : occupancy and occupancy == DEPTH
//   drop            : sticky, set when a push is lost because the FIFO was full
module neuron_result_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [N-1:0]             push_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [N-1:0]             data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          pop_ok;
  logic          push_ok;
  logic          lost;

  assign empty = (count == {(PW + 1){1'b0}});
  assign full  = (count == CNT_MAX);
  assign valid = ~empty;
  assign data  = empty ? {N{1'b0}} : mem[rd_ptr];

  // Push/pop qualification; a pop in the same cycle frees the slot a full push needs.
  always_comb begin
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    lost    = 1'b0;
    pop_ok  = ready & ~empty;
    if (push) begin
      if (full & ~pop_ok) begin
        lost = 1'b1;
      end else begin
        push_ok = 1'b1;
      end
    end else begin
      push_ok = 1'b0;
    end
  end

  // Storage, pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {N{1'b0}};
      end
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {(PW + 1){1'b0}};
      drop   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (lost) begin
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/neuron_datapath.sv
// neuron_datapath: multiply-accumulate datapath with scaled, saturated results
// queued into a small FIFO.
//   clk, rst                : clock, asynchronous active-high reset
//   x_in, w_in              : sample and weight, loaded on write_x / write_w
//   acc_write, clear_acc    : accumulate x_reg*w_reg / zero the accumulator
//   res_write               : push the scaled pre-update accumulator into the FIFO
//   res_valid/res_ready     : FIFO head handshake, res_data is the head value
//   res_count, buf_full     : FIFO occupancy and full flag
//   acc_ovf, drop           : sticky accumulator-wrap and lost-push flags
// Optional build macro NEURON_RELU_EN: clamp negative results to 0 before the push.
module neuron_datapath
  import neuron_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           x_in,
  input  logic [N-1:0]           w_in,
  input  logic                   write_x,
  input  logic                   write_w,
  input  logic                   acc_write,
  input  logic                   clear_acc,
  input  logic                   res_write,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [N-1:0]           res_data,
  output logic [$clog2(DEPTH):0] res_count,
  output logic                   buf_full,
  output logic                   acc_ovf,
  output logic                   drop
);

  logic signed [N-1:0]     x_reg;
  logic signed [N-1:0]     w_reg;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic                    ovf_next;
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    add_ovf;
  logic signed [63:0]      acc_wide;
  logic signed [31:0]      r_full;
  logic [N-1:0]            r_sat;
  logic [N-1:0]            push_val;
  logic                    unused_sat_bits;

  // Product uses the registers as they stood before this cycle's loads.
  assign prod     = x_reg * w_reg;
  assign prod_ext = ACC_W'(prod);
  assign acc_sum  = acc + prod_ext;
  // Two's complement overflow: operands agree in sign, sum disagrees.
  assign add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);

  // Result is always taken from the pre-update accumulator.
  assign acc_wide        = 64'(acc);
  assign r_full          = sat_shift(acc_wide, FRAC, N);
  assign r_sat           = r_full[N-1:0];
  assign unused_sat_bits = ^r_full[31:N];

`ifdef NEURON_RELU_EN
  assign push_val = r_sat[N-1] ? {N{1'b0}} : r_sat;
`else
  assign push_val = r_sat;
`endif

  // Operand registers load independently on their strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= {N{1'b0}};
      w_reg <= {N{1'b0}};
    end else begin
      if (write_x) begin
        x_reg <= x_in;
      end
      if (write_w) begin
        w_reg <= w_in;
      end
    end
  end

  // Accumulator next state: clear wins over accumulate, otherwise hold.
  always_comb begin
    acc_next = acc;
    ovf_next = acc_ovf;
    if (clear_acc) begin
      acc_next = {ACC_W{1'b0}};
    end else if (acc_write) begin
      acc_next = acc_sum;
      ovf_next = acc_ovf | add_ovf;
    end else begin
      acc_next = acc;
    end
  end

  // Accumulator and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= {ACC_W{1'b0}};
      acc_ovf <= 1'b0;
    end else begin
      acc     <= acc_next;
      acc_ovf <= ovf_next;
    end
  end

  neuron_result_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_write),
    .push_data (push_val),
    .ready     (res_ready),
    .valid     (res_valid),
    .data      (res_data),
    .count     (res_count),
    .full      (buf_full),
    .drop      (drop)
  );

endmodule

// File: tb/tb_neuron_datapath.sv
// tb_neuron_datapath: directed self-checking bench for neuron_datapath.
module tb_neuron_datapath;

  logic       clk;
  logic       rst;
  logic [7:0] x_in;
  logic [7:0] w_in;
  logic       write_x;
  logic       write_w;
  logic       acc_write;
  logic       clear_acc;
  logic       res_write;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_count;
  logic       buf_full;
  logic       acc_ovf;
  logic       drop;

  int checks;
  int failures;

  neuron_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .w_in      (w_in),
    .write_x   (write_x),
    .write_w   (write_w),
    .acc_write (acc_write),
    .clear_acc (clear_acc),
    .res_write (res_write),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count),
    .buf_full  (buf_full),
    .acc_ovf   (acc_ovf),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_x   = 1'b0;
    write_w   = 1'b0;
    acc_write = 1'b0;
    clear_acc = 1'b0;
    res_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Load x and w in one cycle, then accumulate once.
  task automatic mac(input int x, input int w);
    x_in = 8'(x); w_in = 8'(w); write_x = 1'b1; write_w = 1'b1;
    tick();
    write_x = 1'b0; write_w = 1'b0; acc_write = 1'b1;
    tick();
    acc_write = 1'b0;
  endtask

  task automatic clear();
    clear_acc = 1'b1;
    tick();
    clear_acc = 1'b0;
  endtask

  task automatic push_now();
    res_write = 1'b1;
    tick();
    res_write = 1'b0;
  endtask

  // Fill an empty FIFO with 1,2,3,4 (res_ready must be 0); leaves acc = 80.
  task automatic fill_1_to_4();
    clear();
    x_in = 8'd16; w_in = 8'd1; write_x = 1'b1; write_w = 1'b1;
    tick();
    write_x = 1'b0; write_w = 1'b0; acc_write = 1'b1;
    tick();
    res_write = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    res_write = 1'b0; acc_write = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({res_valid, res_data, res_count, buf_full, acc_ovf, drop} !== 15'd0) begin
      $display("FAIL reset_outputs got valid=%0b data=%h count=%0d full=%0b ovf=%0b drop=%0b want all 0",
               res_valid, res_data, res_count, buf_full, acc_ovf, drop);
      failures++;
    end
  endtask

  task automatic test_dot_product();
    res_ready = 1'b1;
    clear();
    mac(3, 5);
    mac(-2, 4);
    push_now();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h00) begin
      $display("FAIL dot_small got valid=%0b data=%h want valid=1 data=00", res_valid, res_data);
      failures++;
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || res_count !== 3'd0) begin
      $display("FAIL dot_drain got valid=%0b count=%0d want 0 0", res_valid, res_count);
      failures++;
    end
    clear();
    mac(8, 10);
    push_now();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h05) begin
      $display("FAIL dot_0x50 got valid=%0b data=%h want valid=1 data=05", res_valid, res_data);
      failures++;
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [7:0] exp_neg;
`ifdef NEURON_RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'h80;
`endif
    res_ready = 1'b1;
    clear();
    mac(127, 127);
    acc_write = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    acc_write = 1'b0;
    push_now();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h7F) begin
      $display("FAIL sat_pos got valid=%0b data=%h want valid=1 data=7f", res_valid, res_data);
      failures++;
    end
    tick();
    clear();
    mac(-128, 127);
    acc_write = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    acc_write = 1'b0;
    push_now();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp_neg) begin
      $display("FAIL sat_neg got valid=%0b data=%h want valid=1 data=%h", res_valid, res_data, exp_neg);
      failures++;
    end
    tick();
  endtask

  task automatic test_simultaneous();
    res_ready = 1'b1;
    clear();
    mac(8, 8);
    clear_acc = 1'b1; acc_write = 1'b1; res_write = 1'b1;
    tick();
    clear_acc = 1'b0; acc_write = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h04) begin
      $display("FAIL simul_push got valid=%0b data=%h want valid=1 data=04", res_valid, res_data);
      failures++;
    end
    // res_write still high: pushes the now-cleared accumulator while 4 pops.
    tick();
    res_write = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h00 || res_count !== 3'd1) begin
      $display("FAIL simul_cleared got valid=%0b data=%h count=%0d want 1 00 1", res_valid, res_data, res_count);
      failures++;
    end
    tick();
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h04;
    do_reset();
    res_ready = 1'b0;
    fill_1_to_4();
    checks++;
    if (buf_full !== 1'b1 || res_count !== 3'd4 || drop !== 1'b0 || res_data !== 8'h01) begin
      $display("FAIL full_state got full=%0b count=%0d drop=%0b data=%h want 1 4 0 01",
               buf_full, res_count, drop, res_data);
      failures++;
    end
    push_now();
    checks++;
    if (drop !== 1'b1 || res_count !== 3'd4 || res_data !== 8'h01) begin
      $display("FAIL full_drop got drop=%0b count=%0d data=%h want 1 4 01", drop, res_count, res_data);
      failures++;
    end
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_q[i]) begin
        $display("FAIL full_order[%0d] got valid=%0b data=%h want 1 %h", i, res_valid, res_data, exp_q[i]);
        failures++;
      end
      tick();
    end
    checks++;
    if (res_valid !== 1'b0 || res_data !== 8'h00 || res_count !== 3'd0) begin
      $display("FAIL full_empty got valid=%0b data=%h count=%0d want 0 00 0", res_valid, res_data, res_count);
      failures++;
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h05;
    do_reset();
    res_ready = 1'b0;
    fill_1_to_4();
    res_ready = 1'b1; res_write = 1'b1;
    tick();
    res_write = 1'b0;
    checks++;
    if (res_count !== 3'd4 || drop !== 1'b0 || buf_full !== 1'b1) begin
      $display("FAIL pushpop_full got count=%0d drop=%0b full=%0b want 4 0 1", res_count, drop, buf_full);
      failures++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_q[i]) begin
        $display("FAIL pushpop_order[%0d] got valid=%0b data=%h want 1 %h", i, res_valid, res_data, exp_q[i]);
        failures++;
      end
      tick();
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    res_ready = 1'b0;
    mac(127, 127);
    acc_write = 1'b1;
    // 32 adds of 16129 = 516128 still fits below 2^19; the 33rd wraps.
    for (int i = 0; i < 31; i++) tick();
    acc_write = 1'b0;
    checks++;
    if (acc_ovf !== 1'b0) begin
      $display("FAIL wrap_before got ovf=%0b want 0", acc_ovf);
      failures++;
    end
    acc_write = 1'b1;
    tick();
    acc_write = 1'b0;
    checks++;
    if (acc_ovf !== 1'b1) begin
      $display("FAIL wrap_set got ovf=%0b want 1", acc_ovf);
      failures++;
    end
    acc_write = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    acc_write = 1'b0;
    clear();
    checks++;
    if (acc_ovf !== 1'b1) begin
      $display("FAIL wrap_sticky got ovf=%0b want 1", acc_ovf);
      failures++;
    end
    mac(16, 1);
    push_now();
    push_now();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({res_valid, res_data, res_count, buf_full, acc_ovf, drop} !== 15'd0) begin
      $display("FAIL async_reset got valid=%0b data=%h count=%0d full=%0b ovf=%0b drop=%0b want all 0",
               res_valid, res_data, res_count, buf_full, acc_ovf, drop);
      failures++;
    end
    tick();
    rst = 1'b0;
    tick();
    // Accumulator must also have been discarded: a fresh push reads 0.
    res_ready = 1'b1;
    push_now();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h00 || res_count !== 3'd1) begin
      $display("FAIL reset_acc got valid=%0b data=%h count=%0d want 1 00 1", res_valid, res_data, res_count);
      failures++;
    end
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    x_in      = 8'd0;
    w_in      = 8'd0;
    res_ready = 1'b0;
    idle();
    test_reset();
    test_dot_product();
    test_saturation();
    test_simultaneous();
    test_fifo_full();
    test_full_push_pop();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
